// File: rtl/axis_pattern_gen_pkg.sv
// axis_pattern_gen_pkg: register indices, response codes, address mask and FSM states shared by the pattern generator
package axis_pattern_gen_pkg;
  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_BEATS = 5'd1;
  localparam logic [4:0] REG_FRAMES = 5'd2;
  localparam logic [4:0] REG_SEED = 5'd3;
  localparam logic [4:0] REG_SENT = 5'd4;
  localparam logic [1:0] RESP_OKAY = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [31:0] ADDR_MASK = 32'h7F;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite slave core presenting single-cycle write/read strobes to a register handler
// ports: clk/resetn, S_AXI_* bus, ashi_write/waddr/wdata -> wresp, ashi_read/raddr -> rdata/rresp, widle/ridle
module axi4_lite_slave (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [31:0] ashi_waddr,
  output logic [31:0] ashi_wdata,
  output logic        ashi_write,
  input  logic [1:0]  ashi_wresp,
  input  logic        ashi_widle,
  output logic [31:0] ashi_raddr,
  output logic        ashi_read,
  input  logic [31:0] ashi_rdata,
  input  logic [1:0]  ashi_rresp,
  input  logic        ashi_ridle
);
  logic [1:0] ws, rs;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB};
  // address and data are taken together; the handler answers during its one-cycle strobe
  assign S_AXI_AWREADY = ws == 2'd0 && ashi_widle && S_AXI_AWVALID && S_AXI_WVALID;
  assign S_AXI_WREADY = S_AXI_AWREADY;
  assign ashi_write = ws == 2'd1;
  assign S_AXI_BVALID = ws == 2'd2;
  assign S_AXI_ARREADY = rs == 2'd0 && ashi_ridle && S_AXI_ARVALID;
  assign ashi_read = rs == 2'd1;
  assign S_AXI_RVALID = rs == 2'd2;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws <= 2'd0;
      rs <= 2'd0;
      ashi_waddr <= '0;
      ashi_wdata <= '0;
      ashi_raddr <= '0;
      S_AXI_BRESP <= 2'd0;
      S_AXI_RRESP <= 2'd0;
      S_AXI_RDATA <= '0;
    end else begin
      ws <= S_AXI_AWREADY ? 2'd1 : ws == 2'd1 ? 2'd2 : (ws == 2'd2 && S_AXI_BREADY) ? 2'd0 : ws;
      rs <= S_AXI_ARREADY ? 2'd1 : rs == 2'd1 ? 2'd2 : (rs == 2'd2 && S_AXI_RREADY) ? 2'd0 : rs;
      if (S_AXI_AWREADY) begin
        ashi_waddr <= S_AXI_AWADDR;
        ashi_wdata <= S_AXI_WDATA;
      end
      if (S_AXI_ARREADY) ashi_raddr <= S_AXI_ARADDR;
      if (ashi_write) S_AXI_BRESP <= ashi_wresp;
      if (ashi_read) begin
        S_AXI_RDATA <= ashi_rdata;
        S_AXI_RRESP <= ashi_rresp;
      end
    end
  end
endmodule

// File: rtl/patgen_beat_builder.sv
// patgen_beat_builder: replicates base + i into each 32-bit lane i of a STREAM_WIDTH-bit beat
// ports: base (lane-0 value), beat (assembled beat data)
module patgen_beat_builder import axis_pattern_gen_pkg::*; #(
  parameter int STREAM_WIDTH = 512
) (
  input  logic [31:0]             base,
  output logic [STREAM_WIDTH-1:0] beat
);
  for (genvar i = 0; i < STREAM_WIDTH / 32; i++) begin : g_lane
    assign beat[32*i +: 32] = base + 32'(i);
  end
endmodule

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI4-Lite controlled AXI4-Stream source of framed counting-pattern beats
// ports: clk/resetn, S_AXI_* control slave, AXIS_TX_TDATA/TVALID/TLAST out, AXIS_TX_TREADY in
module axis_pattern_gen import axis_pattern_gen_pkg::*; #(
  parameter int STREAM_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [31:0]             S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [STREAM_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  input  logic                    AXIS_TX_TREADY
);
  localparam int L = STREAM_WIDTH / 32;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic [1:0] wresp, rresp;
  logic write, read;
  logic [4:0] widx, ridx;
  logic [31:0] beats, frames, seed, sent, sh_beats, sh_frames, base, beat_cnt;
  logic [31:0] base_n, cnt_n, sent_n;
  logic hs, start, stop, done;
  logic [STREAM_WIDTH-1:0] beat;
  state_t state, state_n;
  axi4_lite_slave u_slave (
    .clk, .resetn,
    .S_AXI_AWADDR, .S_AXI_AWPROT, .S_AXI_AWVALID, .S_AXI_AWREADY,
    .S_AXI_WDATA, .S_AXI_WSTRB, .S_AXI_WVALID, .S_AXI_WREADY,
    .S_AXI_BRESP, .S_AXI_BVALID, .S_AXI_BREADY,
    .S_AXI_ARADDR, .S_AXI_ARPROT, .S_AXI_ARVALID, .S_AXI_ARREADY,
    .S_AXI_RDATA, .S_AXI_RRESP, .S_AXI_RVALID, .S_AXI_RREADY,
    .ashi_waddr(waddr), .ashi_wdata(wdata), .ashi_write(write), .ashi_wresp(wresp), .ashi_widle(!write),
    .ashi_raddr(raddr), .ashi_read(read), .ashi_rdata(rdata), .ashi_rresp(rresp), .ashi_ridle(!read)
  );
  // in IDLE the builder prepares the first beat from SEED, otherwise the beat after the current one
  patgen_beat_builder #(.STREAM_WIDTH(STREAM_WIDTH)) u_build (
    .base(state == IDLE ? seed : base_n),
    .beat
  );
  assign widx = 5'((waddr & ADDR_MASK) >> 2);
  assign ridx = 5'((raddr & ADDR_MASK) >> 2);
  assign wresp = widx <= REG_SEED ? RESP_OKAY : RESP_DECERR;
  assign rresp = ridx <= REG_SENT ? RESP_OKAY : RESP_DECERR;
  assign rdata = ridx == REG_CTRL ? {30'b0, state == DRAIN, state != IDLE}
    : ridx == REG_BEATS ? beats : ridx == REG_FRAMES ? frames
    : ridx == REG_SEED ? seed : ridx == REG_SENT ? sent : '0;
  assign hs = AXIS_TX_TVALID && AXIS_TX_TREADY;
  assign start = write && widx == REG_CTRL && wdata != '0 && state == IDLE;
  assign stop = write && widx == REG_CTRL && wdata == '0;
  assign base_n = base + 32'(L);
  assign cnt_n = AXIS_TX_TLAST ? '0 : beat_cnt + 32'd1;
  assign sent_n = sent + 32'd1;
  // a frame is never truncated: the run ends only on a TLAST handshake
  assign done = hs && AXIS_TX_TLAST &&
    (state == DRAIN || stop || (sh_frames != '0 && sent_n == sh_frames));
  always_comb begin
    state_n = start ? RUN : done ? IDLE : (stop && state == RUN) ? DRAIN : state;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      beats <= 32'd1;
      frames <= '0;
      seed <= '0;
      sent <= '0;
      sh_beats <= 32'd1;
      sh_frames <= '0;
      base <= '0;
      beat_cnt <= '0;
      AXIS_TX_TDATA <= '0;
      AXIS_TX_TVALID <= 1'b0;
      AXIS_TX_TLAST <= 1'b0;
    end else begin
      state <= state_n;
      if (write && widx == REG_BEATS) beats <= wdata;
      if (write && widx == REG_FRAMES) frames <= wdata;
      if (write && widx == REG_SEED) seed <= wdata;
      if (start) begin
        sh_beats <= beats == '0 ? 32'd1 : beats;
        sh_frames <= frames;
        base <= seed;
        beat_cnt <= '0;
        sent <= '0;
        AXIS_TX_TDATA <= beat;
        AXIS_TX_TVALID <= 1'b1;
        AXIS_TX_TLAST <= beats <= 32'd1;
      end else if (hs) begin
        base <= base_n;
        beat_cnt <= cnt_n;
        sent <= AXIS_TX_TLAST ? sent_n : sent;
        AXIS_TX_TDATA <= beat;
        AXIS_TX_TVALID <= !done;
        AXIS_TX_TLAST <= !done && cnt_n == sh_beats - 32'd1;
      end
    end
  end
endmodule

// File: doc/axis_pattern_gen.md
# axis_pattern_gen

Register-controlled AXI4-Stream pattern source for the pattern-generator datapath. It emits frames of deterministic counting-pattern beats on a STREAM_WIDTH-bit AXI4-Stream master, which feeds the stream output selector's input directly. Software configures and starts it through an AXI4-Lite slave built on the existing `axi4_lite_slave` core.

## Interface
- STREAM_WIDTH, 512, stream data width in bits; multiple of 32; lanes L = STREAM_WIDTH/32.
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- S_AXI_AW*/W*/B*/AR*/R*  in/out  per AXI4-Lite (32-bit addr/data, WSTRB 4, PROT 3, RESP 2)  control slave.
- AXIS_TX_TDATA  out  STREAM_WIDTH  beat data.
- AXIS_TX_TVALID  out  1  beat valid.
- AXIS_TX_TLAST  out  1  last beat of frame.
- AXIS_TX_TREADY  in  1  downstream ready.

## Operation
- Register map (byte offset, index = (addr & 0x7F) >> 2):
  - 0x00 CTRL: write nonzero = start, write 0 = stop request; read bit0 = busy (state != IDLE), bit1 = stop pending.
  - 0x04 BEATS: beats per frame, 32 bits, R/W; value 0 is treated as 1.
  - 0x08 FRAMES: frames per run, 32 bits, R/W; 0 = run until stopped.
  - 0x0C SEED: first-beat base value, 32 bits, R/W.
  - 0x10 SENT: read-only count of completed frames in the current or last run; writes return DECERR.
  - Any other index: DECERR on read and write. Every response is OKAY unless stated otherwise.
- Start, accepted only in IDLE: copy BEATS/FRAMES/SEED into shadow registers, set base = SEED, beat_cnt = 0, SENT = 0, and enter RUN. Start in RUN/DRAIN is ignored with OKAY response.
- Config writes while busy update the registers only; the active run uses the shadow copies.
- Beat data: lane i (bits 32i+31:32i) = base + i, mod 2^32. After each handshake (TVALID && TREADY), base += L, wrapping mod 2^32. Base continues across frames and reloads only at start.
- TLAST = 1 when beat_cnt == shadow_beats - 1. On a TLAST handshake: beat_cnt = 0 and SENT++.
- FSM:
  - IDLE: TVALID = 0.
  - RUN: TVALID = 1. Stop request -> DRAIN. TLAST handshake with FRAMES != 0 and SENT+1 == FRAMES -> IDLE.
  - DRAIN: TVALID = 1 until the current frame's TLAST handshake, then IDLE. Frames are never truncated.
- Stop in IDLE: no effect. Stop and the final TLAST handshake in the same cycle: go to IDLE.
- TDATA/TLAST/TVALID hold stable while TVALID && !TREADY (AXI4-Stream rule).

## Timing
- Reset values: TVALID = 0, TLAST = 0, TDATA = 0, state IDLE, SENT = 0, BEATS = 1, FRAMES = 0, SEED = 0; AXI-Lite outputs as the slave core defines.
- Start accepted in cycle N (ashi_write high): TVALID = 1 with beat 0 in cycle N+1.
- In RUN, one beat per cycle at full throughput when TREADY is held high.
- TDATA and TLAST are registered outputs: the next beat is valid the cycle after a handshake, with no bubble.
- Frame completion to IDLE: TVALID = 0 in the cycle after the final handshake.
- Reset mid-frame: all state returns to reset values on the next clock edge. No TLAST is issued.
- The slave handler idles (ashi_widle/ashi_ridle) when its start strobe is low and its state is 0. Both handlers are single-cycle.

## Structure
- Shared package axis_pattern_gen_pkg: register index constants (CTRL, BEATS, FRAMES, SEED, SENT), the RESP codes OKAY = 0, SLVERR = 2, DECERR = 3, ADDR_MASK = 0x7F, and the FSM state enum IDLE/RUN/DRAIN.
- Instantiate `axi4_lite_slave` for the bus.
- One sub-module is natural: patgen_beat_builder (combinational lane replication base + i for L lanes, parameterised by STREAM_WIDTH).

## Test plan
- BEATS = 4, FRAMES = 2, SEED = 0x100, TREADY = 1, start: 8 beats; lane0 values 0x100, 0x110, …, 0x170 at L = 16; TLAST on beats 3 and 7; then IDLE with SENT = 2.
- TREADY toggling in a 1-0-0-1 pattern during a run: TDATA/TLAST stay stable while stalled; no beat is lost or duplicated; the scoreboard matches the pattern.
- FRAMES = 0, BEATS = 3, stop written mid-frame at beat 1: beat 2 is sent with TLAST, then TVALID = 0 and CTRL reads 0.
- SEED = 0xFFFFFFF8, L = 16: lane 8 of beat 0 = 0x00000000; beat 1 lane0 = 0x00000008 (wrap).
- BEATS = 0: every beat has TLAST = 1. Write 0x0C during a run: the pattern is unchanged until the next start. Read 0x40: DECERR. Write 0x10: DECERR.
- resetn low for 1 cycle during RUN: the next cycle shows TVALID = 0 and SENT = 0, and registers hold reset values.
